// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register slice.
// Holds the mode select encodings used by the register mux and the
// serializer FSM state type used by the serializer controller.
package shift_reg_pkg;

  // Operation select encodings driven on the 3-bit mode input
  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  // Serializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/shift_reg_univ_ser.sv
// shift_ser_ctrl: serializer controller for shift_reg_univ.
// Runs the IDLE/SHIFT/DONE FSM and the bit counter, owns the registered
// serial outputs, and tells the register datapath when to load, when to
// shift, and when ordinary mode operations are allowed.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request to serialize the word currently on data
//   ser_bit    : bit of q that leaves the register on the next shift
//   load       : datapath strobe, load q from data (start accepted)
//   shift      : datapath strobe, shift q with zero fill
//   mode_en    : mode operations allowed this cycle (idle, no start)
//   ser_out    : registered serial bit
//   ser_valid  : ser_out carries a valid bit
//   busy       : serialization in progress
//   done       : one-cycle pulse after the last bit
module shift_ser_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ser_bit,
  output logic load,
  output logic shift,
  output logic mode_en,
  output logic ser_out,
  output logic ser_valid,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  ser_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes. start is only looked at in IDLE, so
  // a start held high through DONE is picked up on the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    mode_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          mode_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counter and registered serial outputs. done defaults low so it can
  // only ever be a single-cycle pulse out of DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cnt_q <= CW'(WIDTH);
        busy  <= 1'b1;
      end
      if (shift) begin
        ser_out   <= ser_bit;
        ser_valid <= 1'b1;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
      if (state_q == ST_DONE) begin
        ser_valid <= 1'b0;
        done      <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register with a built-in
// parallel-to-serial converter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en, mode          : run the selected mode operation while idle
//   data              : parallel load value (also the word to serialize)
//   sin_l, sin_r      : serial inputs at the MSB / LSB end
//   start             : begin serializing data
//   q                 : register contents
//   sout_msb/sout_lsb : q[WIDTH-1] / q[0], combinational
//   ser_out/ser_valid : registered serial bit and its valid flag
//   busy, done        : serializer active / end-of-word pulse
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  logic load, shift, mode_en, ser_bit;

  // The bit that leaves the register on a serializer shift
  assign ser_bit  = LSB_FIRST ? q[0] : q[WIDTH-1];
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  shift_ser_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_bit   (ser_bit),
    .load      (load),
    .shift     (shift),
    .mode_en   (mode_en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  // Register and mode mux. Serializer strobes take precedence over the
  // mode operations, which only run when the controller grants mode_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      q <= LSB_FIRST ? {1'b0, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
    end else if (mode_en && en) begin
      case (mode)
        MODE_HOLD: q <= q;
        MODE_LOAD: q <= data;
        MODE_SHL:  q <= {q[WIDTH-2:0], sin_r};
        MODE_SHR:  q <= {sin_l, q[WIDTH-1:1]};
        MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
        MODE_ASR:  q <= {q[WIDTH-1], q[WIDTH-1:1]};
        MODE_CLR:  q <= '0;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed testbench for shift_reg_univ: an 8-bit LSB-first instance for
// the mode and serializer checks and a 4-bit MSB-first instance for bit
// order. Inputs change and outputs are sampled 1 time unit after posedge.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, start, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] data, q;
  logic       sout_msb, sout_lsb, ser_out, ser_valid, busy, done;

  logic       en2, start2;
  logic [3:0] data2, q2;
  logic       sout_msb2, sout_lsb2, ser_out2, ser_valid2, busy2, done2;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data(data),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .ser_out(ser_out),
    .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  shift_reg_univ #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
    .clk(clk), .rst(rst), .en(en2), .mode(MODE_HOLD), .data(data2),
    .sin_l(1'b0), .sin_r(1'b0), .start(start2), .q(q2),
    .sout_msb(sout_msb2), .sout_lsb(sout_lsb2), .ser_out(ser_out2),
    .ser_valid(ser_valid2), .busy(busy2), .done(done2)
  );

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the main instance's control inputs and advance one edge
  task automatic applyStimulus(input logic e, input logic [2:0] m,
                               input logic [7:0] d, input logic s);
    en = e; mode = m; data = d; start = s;
    tick();
    start = 1'b0;
  endtask

  // Check an 8-bit word stream from the main instance; start pulse already
  // applied. Optionally stirs start/mode/data during busy to prove they
  // are ignored.
  task automatic checkStream(input string tag, input logic [7:0] bits,
                             input logic disturb);
    for (int i = 0; i < 8; i++) begin
      if (disturb) begin
        start = (i < 4); en = 1'b1; mode = MODE_CLR; data = 8'h00;
      end
      tick();
      checkOutput({tag, "_valid"}, ser_valid, 1'b1);
      checkOutput({tag, "_bit"}, ser_out, bits[i]);
      checkOutput({tag, "_busy"}, busy, 1'b1);
      checkOutput({tag, "_nodone"}, done, 1'b0);
    end
    start = 1'b0; mode = MODE_HOLD;
    tick();
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_busyfall"}, busy, 1'b0);
    checkOutput({tag, "_validfall"}, ser_valid, 1'b0);
    checkOutput({tag, "_qzero"}, q, 8'h00);
    tick();
    checkOutput({tag, "_donepulse"}, done, 1'b0);
  endtask

  logic [2:0] modeTab [6] = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR};
  logic [7:0] expTab  [6] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'hD2, 8'h00};
  logic [3:0] bits4 = 4'b1000;

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; data = '0; start = 1'b0;
    sin_l = 1'b0; sin_r = 1'b1; en2 = 1'b0; start2 = 1'b0; data2 = '0;
    tick(); tick();
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_valid", ser_valid, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_serout", ser_out, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b1, MODE_LOAD, 8'hA5, 1'b0);
    checkOutput("load", q, 8'hA5);
    checkOutput("sout_msb", sout_msb, 1'b1);
    checkOutput("sout_lsb", sout_lsb, 1'b1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, MODE_LOAD, 8'hA5, 1'b0);
      applyStimulus(1'b1, modeTab[i], 8'h00, 1'b0);
      checkOutput($sformatf("mode%0d", modeTab[i]), q, expTab[i]);
    end

    applyStimulus(1'b1, MODE_LOAD, 8'hA5, 1'b0);
    applyStimulus(1'b0, MODE_ROL, 8'h00, 1'b0);
    checkOutput("en0_hold", q, 8'hA5);
    applyStimulus(1'b1, MODE_HOLD, 8'h3C, 1'b0);
    checkOutput("mode_hold", q, 8'hA5);

    // Basic serialization of 8'b1011_0010
    applyStimulus(1'b0, MODE_HOLD, 8'b1011_0010, 1'b1);
    checkOutput("ser_busy", busy, 1'b1);
    checkOutput("ser_loadq", q, 8'hB2);
    checkOutput("ser_novalid", ser_valid, 1'b0);
    checkStream("ser", 8'b1011_0010, 1'b0);

    // start beats LOAD in the same cycle; activity during busy ignored
    applyStimulus(1'b1, MODE_LOAD, 8'b1011_0010, 1'b1);
    checkOutput("startwin_busy", busy, 1'b1);
    checkStream("ignore", 8'b1011_0010, 1'b1);

    // Reset after the third valid bit aborts with no done pulse
    applyStimulus(1'b0, MODE_HOLD, 8'b1011_0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("pre_abort_valid", ser_valid, 1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_q", q, 8'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_valid", ser_valid, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_nodone", done, 1'b0);
      checkOutput("abort_idle", busy, 1'b0);
    end
    applyStimulus(1'b0, MODE_HOLD, 8'hFF, 1'b1);
    checkStream("ones", 8'hFF, 1'b0);

    // 4-bit MSB-first instance
    data2 = 4'b1000; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checkOutput("w4_busy", busy2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("w4_valid", ser_valid2, 1'b1);
      checkOutput("w4_bit", ser_out2, bits4[3-i]);
      checkOutput("w4_nodone", done2, 1'b0);
    end
    tick();
    checkOutput("w4_done", done2, 1'b1);
    checkOutput("w4_busyfall", busy2, 1'b0);
    checkOutput("w4_qzero", q2, 4'h0);
    tick();
    checkOutput("w4_donepulse", done2, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
